// File: rtl/kv_fpu_fmv_pipe_if.sv
// Request/response bundle for the FP move / sign-injection unit.
// The master is the issuing side; the slave is the unit itself.
interface kv_fpu_fmv_pipe_if #(
  parameter int FLEN  = 64,
  parameter int LANES = 1,
  parameter int TAG_W = 5
);
  logic                   flush;
  logic                   req_valid;
  logic                   req_ready;
  logic [2:0]             req_sew;
  logic [4:0]             req_op;
  logic [LANES*FLEN-1:0]  req_op1;
  logic [LANES*FLEN-1:0]  req_op2;
  logic [TAG_W-1:0]       req_tag;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [LANES*FLEN-1:0]  resp_wdata;
  logic [TAG_W-1:0]       resp_tag;
  logic                   resp_illegal;
  logic                   standby_ready;

  modport master (
    output flush, req_valid, req_sew, req_op, req_op1, req_op2, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_wdata, resp_tag, resp_illegal, standby_ready
  );

  modport slave (
    input  flush, req_valid, req_sew, req_op, req_op1, req_op2, req_tag, resp_ready,
    output req_ready, resp_valid, resp_wdata, resp_tag, resp_illegal, standby_ready
  );
endinterface

// File: rtl/kv_fpu_fmv_pipe.sv
// Multi-lane FMV / FSGNJ unit with NaN-box checking, feeding a 2-entry result queue.
// The queue head is slot 0; a pop shifts slot 1 down.
module kv_fpu_fmv_pipe #(
  parameter int FLEN  = 64,
  parameter int LANES = 1,
  parameter int TAG_W = 5
) (
  input  logic                  core_clk,
  input  logic                  core_reset,
  kv_fpu_fmv_pipe_if.slave      io
);
  localparam int W = LANES * FLEN;

  localparam logic [4:0] OP_FMV_F  = 5'b01110;
  localparam logic [4:0] OP_FMV_X  = 5'b01100;
  localparam logic [4:0] OP_FSGNJ  = 5'b00000;
  localparam logic [4:0] OP_FSGNJN = 5'b00001;
  localparam logic [4:0] OP_FSGNJX = 5'b00010;

  function automatic logic legal_req(input logic [2:0] sew, input logic [4:0] op);
    logic sew_ok;
    logic op_ok;
    sew_ok = (sew == 3'b001) || (sew == 3'b010) || ((sew == 3'b100) && (FLEN == 64));
    op_ok  = op inside {OP_FMV_F, OP_FMV_X, OP_FSGNJ, OP_FSGNJN, OP_FSGNJX};
    return sew_ok && op_ok;
  endfunction

  // Element width selects a box mask above the element; for a full-width
  // element the mask is empty, so the lane always counts as boxed.
  function automatic logic [FLEN-1:0] lane_op(input logic [2:0] sew, input logic [4:0] op,
                                              input logic [FLEN-1:0] x,
                                              input logic [FLEN-1:0] y);
    int              e;
    logic [FLEN-1:0] box, elem, sgn, cnan, mag;
    logic            xb, yb, xs, ys, s;
    case (sew)
      3'b001:  e = 16;
      3'b010:  e = 32;
      default: e = FLEN;
    endcase
    box  = {FLEN{1'b1}} << e;
    elem = ~box;
    sgn  = FLEN'(1) << (e - 1);
    cnan = (e == 16) ? FLEN'(16'h7E00) : FLEN'(32'h7FC0_0000);
    xb   = ((x & box) == box);
    yb   = ((y & box) == box);
    xs   = |(x & sgn);
    ys   = yb & (|(y & sgn));
    mag  = xb ? (x & elem & ~sgn) : cnan;
    s    = ys;
    if (op == OP_FSGNJN) s = ~ys;
    else if ((op == OP_FSGNJX) && xb) s = xs ^ ys;
    case (op)
      OP_FMV_F: lane_op = box | (x & elem);
      OP_FMV_X: lane_op = (x & elem) | (xs ? box : '0);
      default:  lane_op = box | mag | (s ? sgn : '0);
    endcase
  endfunction

  logic [W-1:0]     res_d;
  logic             ill_d;
  logic [1:0]       cnt_d, cnt_q;
  logic [W-1:0]     data_d [2];
  logic [W-1:0]     data_q [2];
  logic [TAG_W-1:0] tag_d  [2];
  logic [TAG_W-1:0] tag_q  [2];
  logic             ille_d [2];
  logic             ille_q [2];
  logic             push, pop, wr_slot, head_vld;

  always_comb begin
    ill_d = !legal_req(io.req_sew, io.req_op);
    res_d = '0;
    if (!ill_d) begin
      for (int i = 0; i < LANES; i++) begin
        res_d[i*FLEN +: FLEN] = lane_op(io.req_sew, io.req_op,
                                        io.req_op1[i*FLEN +: FLEN],
                                        io.req_op2[i*FLEN +: FLEN]);
      end
    end
  end

  assign head_vld = (cnt_q != 2'd0);
  assign push     = io.req_valid && (cnt_q != 2'd2) && !io.flush;
  assign pop      = head_vld && io.resp_ready;
  assign wr_slot  = cnt_q[0] & ~pop;

  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    ille_d = ille_q;
    cnt_d  = cnt_q;
    if (io.flush) begin
      cnt_d = 2'd0;
    end else begin
      if (pop) begin
        data_d[0] = data_q[1];
        tag_d[0]  = tag_q[1];
        ille_d[0] = ille_q[1];
      end
      if (push) begin
        data_d[wr_slot] = res_d;
        tag_d[wr_slot]  = io.req_tag;
        ille_d[wr_slot] = ill_d;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Queue register stage: only the occupancy count is reset
  always_ff @(posedge core_clk) begin
    if (core_reset) cnt_q <= 2'd0;
    else            cnt_q <= cnt_d;
  end

  always_ff @(posedge core_clk) begin
    data_q <= data_d;
    tag_q  <= tag_d;
    ille_q <= ille_d;
  end

  // Outputs are masked by occupancy so unwritten slots never leak out
  assign io.req_ready     = (cnt_q != 2'd2);
  assign io.resp_valid    = head_vld;
  assign io.resp_wdata    = head_vld ? data_q[0] : '0;
  assign io.resp_tag      = head_vld ? tag_q[0]  : '0;
  assign io.resp_illegal  = head_vld & ille_q[0];
  assign io.standby_ready = ~io.req_valid & ~head_vld;
endmodule

// File: tb/tb_kv_fpu_fmv_pipe.sv
// Scoreboard bench for kv_fpu_fmv_pipe: 2-lane FLEN=64 main instance plus a
// 1-lane FLEN=32 instance for the narrow-FLEN rules.
module tb_kv_fpu_fmv_pipe;
  localparam logic [4:0] OP_FMV_F  = 5'b01110;
  localparam logic [4:0] OP_FMV_X  = 5'b01100;
  localparam logic [4:0] OP_FSGNJ  = 5'b00000;
  localparam logic [4:0] OP_FSGNJN = 5'b00001;
  localparam logic [4:0] OP_FSGNJX = 5'b00010;
  localparam logic [2:0] SEW_H = 3'b001, SEW_S = 3'b010, SEW_D = 3'b100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kv_fpu_fmv_pipe_if #(.FLEN(64), .LANES(2), .TAG_W(5)) io ();
  kv_fpu_fmv_pipe_if #(.FLEN(32), .LANES(1), .TAG_W(5)) io32 ();

  kv_fpu_fmv_pipe #(.FLEN(64), .LANES(2), .TAG_W(5)) dut (
    .core_clk(clk), .core_reset(rst), .io(io));
  kv_fpu_fmv_pipe #(.FLEN(32), .LANES(1), .TAG_W(5)) dut32 (
    .core_clk(clk), .core_reset(rst), .io(io32));

  typedef struct {
    logic [127:0] data;
    logic [4:0]   tag;
    logic         ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Reference model: one case per precision, written from the operation rules.
  function automatic logic ref_legal(input logic [4:0] op, input logic [2:0] sew);
    return (sew == SEW_H || sew == SEW_S || sew == SEW_D) &&
           (op == OP_FMV_F || op == OP_FMV_X || op == OP_FSGNJ ||
            op == OP_FSGNJN || op == OP_FSGNJX);
  endfunction

  function automatic logic [63:0] ref_lane(input logic [4:0] op, input logic [2:0] sew,
                                           input logic [63:0] x, input logic [63:0] y);
    logic xb, yb, s;
    logic [30:0] m31;
    logic [14:0] m15;
    case (sew)
      SEW_D: begin
        if (op == OP_FMV_F || op == OP_FMV_X) return x;
        if (op == OP_FSGNJ)  return {y[63], x[62:0]};
        if (op == OP_FSGNJN) return {~y[63], x[62:0]};
        return {x[63] ^ y[63], x[62:0]};
      end
      SEW_S: begin
        if (op == OP_FMV_F) return {32'hFFFF_FFFF, x[31:0]};
        if (op == OP_FMV_X) return {{32{x[31]}}, x[31:0]};
        xb = (x[63:32] == 32'hFFFF_FFFF);
        yb = (y[63:32] == 32'hFFFF_FFFF);
        s  = yb ? y[31] : 1'b0;
        if (op == OP_FSGNJN) s = !s;
        else if (op == OP_FSGNJX && xb) s = s ^ x[31];
        m31 = xb ? x[30:0] : 31'h7FC0_0000;
        return {32'hFFFF_FFFF, s, m31};
      end
      SEW_H: begin
        if (op == OP_FMV_F) return {48'hFFFF_FFFF_FFFF, x[15:0]};
        if (op == OP_FMV_X) return {{48{x[15]}}, x[15:0]};
        xb = (x[63:16] == 48'hFFFF_FFFF_FFFF);
        yb = (y[63:16] == 48'hFFFF_FFFF_FFFF);
        s  = yb ? y[15] : 1'b0;
        if (op == OP_FSGNJN) s = !s;
        else if (op == OP_FSGNJX && xb) s = s ^ x[15];
        m15 = xb ? x[14:0] : 15'h7E00;
        return {48'hFFFF_FFFF_FFFF, s, m15};
      end
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [127:0] ref_data(input logic [4:0] op, input logic [2:0] sew,
                                            input logic [127:0] a, input logic [127:0] b);
    if (!ref_legal(op, sew)) return 128'h0;
    return {ref_lane(op, sew, a[127:64], b[127:64]), ref_lane(op, sew, a[63:0], b[63:0])};
  endfunction

  function automatic logic [63:0] rnd_lane();
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      1, 2:    v[63:32] = '1;
      3:       v[63:16] = '1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) io.resp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [4:0] op, input logic [2:0] sew,
                       input logic [127:0] a, input logic [127:0] b, input logic [4:0] tag,
                       input logic [127:0] exp_d, input logic exp_i);
    exp_t e;
    bit   done;
    done = 0;
    io.req_valid = 1'b1;
    io.req_op    = op;
    io.req_sew   = sew;
    io.req_op1   = a;
    io.req_op2   = b;
    io.req_tag   = tag;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (io.req_ready && !io.flush && !rst) begin
        e.data = exp_d;
        e.tag  = tag;
        e.ill  = exp_i;
        sb.push_back(e);
        done = 1;
      end
      tick();
    end
    io.req_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: tag %0d not accepted, required within 50 cycles", tag);
    end
  endtask

  task automatic issue_m(input logic [4:0] op, input logic [2:0] sew,
                         input logic [127:0] a, input logic [127:0] b, input logic [4:0] tag);
    issue(op, sew, a, b, tag, ref_data(op, sew, a, b), !ref_legal(op, sew));
  endtask

  task automatic issue32(input string name, input logic [4:0] op, input logic [2:0] sew,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_d, input logic exp_i);
    io32.req_valid = 1'b1;
    io32.req_op    = op;
    io32.req_sew   = sew;
    io32.req_op1   = a;
    io32.req_op2   = b;
    io32.req_tag   = 5'd9;
    tick();
    io32.req_valid = 1'b0;
    chk({name, "_valid"}, io32.resp_valid, 1);
    chk(name, {io32.resp_illegal, io32.resp_wdata}, {exp_i, exp_d});
  endtask

  // Monitor: pops the scoreboard on every completed response handshake
  always @(negedge clk) begin
    if (rst || io.flush) begin
      sb.delete();
    end else if (io.resp_valid && io.resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: tag %0d data %h, required no response",
                 io.resp_tag, io.resp_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp", {io.resp_wdata, io.resp_tag, io.resp_illegal}, {e.data, e.tag, e.ill});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ops [5];
    logic [2:0] sews [3];
    logic [4:0] op;
    logic [2:0] sew;
    ops  = '{OP_FMV_F, OP_FMV_X, OP_FSGNJ, OP_FSGNJN, OP_FSGNJX};
    sews = '{SEW_H, SEW_S, SEW_D};

    rst = 1'b1;
    io.flush = 1'b0;  io.req_valid = 1'b0;  io.req_sew = '0;  io.req_op = '0;
    io.req_op1 = '0;  io.req_op2 = '0;  io.req_tag = '0;  io.resp_ready = 1'b1;
    io32.flush = 1'b0;  io32.req_valid = 1'b0;  io32.req_sew = '0;  io32.req_op = '0;
    io32.req_op1 = '0;  io32.req_op2 = '0;  io32.req_tag = '0;  io32.resp_ready = 1'b1;
    repeat (3) tick();

    chk("rst_resp_valid", io.resp_valid, 0);
    chk("rst_resp_illegal", io.resp_illegal, 0);
    chk("rst_resp_tag", io.resp_tag, 0);
    chk("rst_resp_wdata", io.resp_wdata, 0);
    chk("rst_req_ready", io.req_ready, 1);
    chk("rst_standby", io.standby_ready, 1);
    chk("rst32_resp_valid", io32.resp_valid, 0);
    rst = 1'b0;
    tick();

    issue(OP_FSGNJ, SEW_S, {64'hFFFF_FFFF_4000_0000, 64'hFFFF_FFFF_3F80_0000},
          {64'h0, 64'hFFFF_FFFF_BF80_0000}, 5'd10,
          {64'hFFFF_FFFF_4000_0000, 64'hFFFF_FFFF_BF80_0000}, 1'b0);
    chk("latency_valid", io.resp_valid, 1);
    chk("busy_standby", io.standby_ready, 0);
    issue(OP_FSGNJN, SEW_S, {2{64'h0000_0000_3F80_0000}}, {2{64'hFFFF_FFFF_0000_0000}},
          5'd11, {2{64'hFFFF_FFFF_FFC0_0000}}, 1'b0);
    issue(OP_FSGNJX, SEW_S, {2{64'h0000_0000_3F80_0000}}, {2{64'hFFFF_FFFF_0000_0000}},
          5'd12, {2{64'hFFFF_FFFF_7FC0_0000}}, 1'b0);
    issue(OP_FMV_X, SEW_H, {2{64'h0000_0000_0000_8001}}, 128'h0,
          5'd13, {2{64'hFFFF_FFFF_FFFF_8001}}, 1'b0);
    issue(OP_FMV_F, SEW_H, {2{64'h0000_0000_0000_0001}}, 128'h0,
          5'd14, {2{64'hFFFF_FFFF_FFFF_0001}}, 1'b0);
    issue(OP_FSGNJ, SEW_D, {2{64'h3FF0_0000_0000_0000}}, {2{64'h8000_0000_0000_0000}},
          5'd15, {2{64'hBFF0_0000_0000_0000}}, 1'b0);
    issue(OP_FSGNJ, 3'b011, {2{64'hFFFF_FFFF_3F80_0000}}, 128'h0, 5'd16, 128'h0, 1'b1);
    issue(OP_FSGNJ, 3'b011, {2{64'hFFFF_FFFF_3F80_0000}}, 128'h0, 5'd16, 128'h0, 1'b1);
    issue(5'b11111, SEW_S, {2{64'hFFFF_FFFF_3F80_0000}}, 128'h0, 5'd17, 128'h0, 1'b1);
    repeat (3) tick();
    chk("idle_standby", io.standby_ready, 1);

    // Backpressure: two accepted, third held until the consumer drains
    io.resp_ready = 1'b0;
    issue_m(OP_FSGNJX, SEW_S, {rnd_lane(), rnd_lane()}, {rnd_lane(), rnd_lane()}, 5'd1);
    issue_m(OP_FSGNJ, SEW_H, {rnd_lane(), rnd_lane()}, {rnd_lane(), rnd_lane()}, 5'd2);
    chk("bp_full_ready", io.req_ready, 0);
    fork
      issue_m(OP_FMV_X, SEW_S, {rnd_lane(), rnd_lane()}, {rnd_lane(), rnd_lane()}, 5'd3);
      begin
        tick();
        tick();
        chk("bp_held_ready", io.req_ready, 0);
        io.resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_valid_continuous", io.resp_valid, 1);
        end
      end
    join
    repeat (2) tick();

    // Flush with a full queue and a same-cycle request
    io.resp_ready = 1'b0;
    issue_m(OP_FSGNJ, SEW_S, {rnd_lane(), rnd_lane()}, {rnd_lane(), rnd_lane()}, 5'd4);
    issue_m(OP_FSGNJN, SEW_D, {rnd_lane(), rnd_lane()}, {rnd_lane(), rnd_lane()}, 5'd5);
    io.flush = 1'b1;
    io.req_valid = 1'b1;
    io.req_op = OP_FSGNJ;
    io.req_sew = SEW_S;
    io.req_tag = 5'd7;
    tick();
    io.flush = 1'b0;
    io.req_valid = 1'b0;
    chk("flush_resp_valid", io.resp_valid, 0);
    chk("flush_req_ready", io.req_ready, 1);
    io.resp_ready = 1'b1;
    repeat (3) tick();

    // Reset with two entries queued
    io.resp_ready = 1'b0;
    issue_m(OP_FMV_F, SEW_H, {rnd_lane(), rnd_lane()}, {rnd_lane(), rnd_lane()}, 5'd20);
    issue_m(OP_FSGNJX, SEW_D, {rnd_lane(), rnd_lane()}, {rnd_lane(), rnd_lane()}, 5'd21);
    rst = 1'b1;
    tick();
    chk("rstq_resp_valid", io.resp_valid, 0);
    chk("rstq_req_ready", io.req_ready, 1);
    chk("rstq_resp_tag", io.resp_tag, 0);
    rst = 1'b0;
    io.resp_ready = 1'b1;
    repeat (2) tick();

    // Narrow-FLEN instance
    issue32("f32_sew_d_illegal", OP_FSGNJ, SEW_D, 32'h3F80_0000, 32'h8000_0000, 32'h0, 1'b1);
    issue32("f32_fsgnjn_s", OP_FSGNJN, SEW_S, 32'h3F80_0000, 32'h0000_0000, 32'hBF80_0000, 1'b0);
    issue32("f32_fmvf_h", OP_FMV_F, SEW_H, 32'h0000_0001, 32'h0, 32'hFFFF_0001, 1'b0);
    issue32("f32_fsgnj_h_unboxed", OP_FSGNJ, SEW_H, 32'h0000_3C00, 32'hFFFF_8000,
            32'hFFFF_FE00, 1'b0);
    tick();

    // Randomized traffic with random backpressure and occasional flushes
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        io.flush = 1'b1;
        io.req_valid = 1'($urandom_range(0, 1));
        io.req_tag = 5'($urandom);
        tick();
        io.flush = 1'b0;
        io.req_valid = 1'b0;
        chk("rand_flush_valid", io.resp_valid, 0);
      end else begin
        op  = ($urandom_range(0, 19) == 0) ? 5'($urandom) : ops[$urandom_range(0, 4)];
        sew = ($urandom_range(0, 19) == 0) ? 3'($urandom) : sews[$urandom_range(0, 2)];
        issue_m(op, sew, {rnd_lane(), rnd_lane()}, {rnd_lane(), rnd_lane()}, 5'($urandom));
      end
    end
    rand_rdy = 1'b0;
    io.resp_ready = 1'b1;
    repeat (5) tick();
    chk("drain_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
